// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache with line-wide refill
// Hits answer combinationally in IDLE; misses fetch one 4-word line via mem_readM/mem_valid.
module inst_cache #(
    parameter int NUM_LINES  = 8,
    parameter int INDEX_BITS = 3
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic        c_readM,
    input  logic [15:0] c_address,
    output logic [15:0] c_data,
    output logic        c_ready,
    input  logic        flush,
    output logic        mem_readM,
    output logic [15:0] mem_address,
    input  logic [63:0] mem_data,
    input  logic        mem_valid,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int TAG_BITS = 14 - INDEX_BITS;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_LINES-1:0]  r_valid;
    logic [TAG_BITS-1:0]   r_tag  [NUM_LINES];
    logic [63:0]           r_line [NUM_LINES];
    logic [13:0]           r_line_addr;
    logic                  r_mem_readM;
    logic                  r_flush_pend;
    logic [15:0]           r_hit_count;
    logic [15:0]           r_miss_count;

    logic [1:0]            w_offset;
    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_BITS-1:0]   w_fill_tag;
    logic [63:0]           w_line;
    logic                  w_hit;
    logic                  w_start_miss;
    logic                  w_fill;
    logic                  w_fill_flush;

    assign w_offset     = c_address[1:0];
    assign w_index      = c_address[INDEX_BITS+1:2];
    assign w_tag        = c_address[15:INDEX_BITS+2];
    assign w_fill_index = r_line_addr[INDEX_BITS-1:0];
    assign w_fill_tag   = r_line_addr[13:INDEX_BITS];
    assign w_line       = r_line[w_index];

    assign w_hit        = (r_state == S_IDLE) && c_readM && r_valid[w_index]
                          && (r_tag[w_index] == w_tag);
    assign w_start_miss = (r_state == S_IDLE) && c_readM && !w_hit;
    assign w_fill       = (r_state == S_MISS) && mem_valid;
    // A flush raised on the fill cycle itself counts like a pending one.
    assign w_fill_flush = r_flush_pend || flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_miss) w_state_nxt = S_MISS;
            S_MISS:  if (mem_valid)    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        c_data = 16'h0000;
        if (w_hit) begin
            case (w_offset)
                2'd0:    c_data = w_line[15:0];
                2'd1:    c_data = w_line[31:16];
                2'd2:    c_data = w_line[47:32];
                default: c_data = w_line[63:48];
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_line_addr  <= '0;
            r_mem_readM  <= 1'b0;
            r_flush_pend <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                if (flush) r_valid <= '0;
                if (w_start_miss) begin
                    r_line_addr <= c_address[15:2];
                    r_mem_readM <= 1'b1;
                end
            end else if (w_fill) begin
                r_mem_readM  <= 1'b0;
                r_flush_pend <= 1'b0;
                if (w_fill_flush) r_valid <= '0;
                else              r_valid[w_fill_index] <= 1'b1;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end
            if (w_hit && (r_hit_count != 16'hFFFF))
                r_hit_count <= r_hit_count + 16'd1;
            if (w_start_miss && (r_miss_count != 16'hFFFF))
                r_miss_count <= r_miss_count + 16'd1;
        end
    end

    // Line data and tags carry no reset; the valid bits gate them.
    always_ff @(posedge Clk) begin
        if (w_fill) begin
            r_line[w_fill_index] <= mem_data;
            r_tag[w_fill_index]  <= w_fill_tag;
        end
    end

    assign c_ready     = w_hit;
    assign mem_readM   = r_mem_readM;
    assign mem_address = {r_line_addr, 2'b00};
    assign hit_count   = r_hit_count;
    assign miss_count  = r_miss_count;
endmodule
